// File: rtl/vend_pkg.sv
// Shared types, prices and coin helpers for the vending transaction sequencer.
package vend_pkg;

    localparam int unsigned NUM_ITEMS_DEF  = 10;
    localparam int unsigned CREDIT_W_DEF   = 8;
    localparam int unsigned STOCK_INIT_DEF = 3;
    localparam int unsigned MAX_TRANS_DEF  = 3;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned COIN_W  = 3;
    localparam int unsigned VAL_W   = 5;
    localparam int unsigned PRICE_W = 6;

    typedef enum logic [COIN_W-1:0] {
        COIN_1  = 3'd0,
        COIN_2  = 3'd1,
        COIN_5  = 3'd2,
        COIN_10 = 3'd3,
        COIN_20 = 3'd4
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    // Change coin choice together with its dollar value.
    typedef struct packed {
        coin_e            code;
        logic [VAL_W-1:0] value;
    } chg_pick_t;

    localparam logic [PRICE_W-1:0] PRICE_TEA     = 6'd5;
    localparam logic [PRICE_W-1:0] PRICE_COOKIES = 6'd20;
    localparam logic [PRICE_W-1:0] PRICE_COFFEE  = 6'd7;
    localparam logic [PRICE_W-1:0] PRICE_CANDY1  = 6'd10;
    localparam logic [PRICE_W-1:0] PRICE_CANDY2  = 6'd20;
    localparam logic [PRICE_W-1:0] PRICE_CANDY3  = 6'd25;
    localparam logic [PRICE_W-1:0] PRICE_CHOC1   = 6'd30;
    localparam logic [PRICE_W-1:0] PRICE_CHOC2   = 6'd10;
    localparam logic [PRICE_W-1:0] PRICE_CHOC3   = 6'd25;
    localparam logic [PRICE_W-1:0] PRICE_CHOC4   = 6'd50;

    function automatic logic [PRICE_W-1:0] item_price(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    item_price = PRICE_TEA;
            4'd1:    item_price = PRICE_COOKIES;
            4'd2:    item_price = PRICE_COFFEE;
            4'd3:    item_price = PRICE_CANDY1;
            4'd4:    item_price = PRICE_CANDY2;
            4'd5:    item_price = PRICE_CANDY3;
            4'd6:    item_price = PRICE_CHOC1;
            4'd7:    item_price = PRICE_CHOC2;
            4'd8:    item_price = PRICE_CHOC3;
            4'd9:    item_price = PRICE_CHOC4;
            default: item_price = '0;
        endcase
    endfunction

    // Invalid codes map to zero; callers reject them via coin_code_ok.
    function automatic logic [VAL_W-1:0] coin_value(input logic [COIN_W-1:0] code);
        case (code)
            COIN_1:  coin_value = 5'd1;
            COIN_2:  coin_value = 5'd2;
            COIN_5:  coin_value = 5'd5;
            COIN_10: coin_value = 5'd10;
            COIN_20: coin_value = 5'd20;
            default: coin_value = '0;
        endcase
    endfunction

    function automatic logic coin_code_ok(input logic [COIN_W-1:0] code);
        coin_code_ok = (code <= COIN_20);
    endfunction

endpackage

// File: rtl/vend_txn_sequencer_if.sv
// Dispenser-side ready/valid handshakes for items and change coins.
interface vend_txn_sequencer_if;
    import vend_pkg::*;

    logic              disp_valid;
    logic [IDX_W-1:0]  disp_idx;
    logic              disp_ready;
    logic              chg_valid;
    logic [COIN_W-1:0] chg_code;
    logic              chg_ready;

    modport master (
        output disp_valid, disp_idx, chg_valid, chg_code,
        input  disp_ready, chg_ready
    );

    modport slave (
        input  disp_valid, disp_idx, chg_valid, chg_code,
        output disp_ready, chg_ready
    );

endinterface

// File: rtl/change_picker.sv
// Greedy change selection: largest denomination not exceeding the credit.
module change_picker
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = CREDIT_W_DEF
) (
    input  logic [CREDIT_W-1:0] credit,
    output chg_pick_t           pick_c
);

    always_comb begin
        pick_c = '{code: COIN_1, value: '0};
        if (credit >= CREDIT_W'(20)) begin
            pick_c = '{code: COIN_20, value: 5'd20};
        end else if (credit >= CREDIT_W'(10)) begin
            pick_c = '{code: COIN_10, value: 5'd10};
        end else if (credit >= CREDIT_W'(5)) begin
            pick_c = '{code: COIN_5, value: 5'd5};
        end else if (credit >= CREDIT_W'(2)) begin
            pick_c = '{code: COIN_2, value: 5'd2};
        end else if (credit != '0) begin
            pick_c = '{code: COIN_1, value: 5'd1};
        end
    end

endmodule

// File: rtl/vend_txn_sequencer.sv
// Vending transaction controller: credit, stock and session limit bookkeeping,
// item dispensing and greedy change return over ready/valid handshakes.
module vend_txn_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS       = NUM_ITEMS_DEF,
    parameter int unsigned CREDIT_W        = CREDIT_W_DEF,
    parameter int unsigned STOCK_INIT      = STOCK_INIT_DEF,
    parameter int unsigned MAX_TRANSACTION = MAX_TRANS_DEF
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  coin_valid,
    input  logic [COIN_W-1:0]     coin_code,
    input  logic                  sel_valid,
    input  logic [IDX_W-1:0]      sel_idx,
    input  logic                  refund_req,
    input  logic                  free_mode,
    input  logic                  restock,
    vend_txn_sequencer_if.master  bus,
    output logic [CREDIT_W-1:0]   credit,
    output logic [NUM_ITEMS-1:0]  sold_out,
    output logic                  coin_reject,
    output logic                  low_credit,
    output logic                  busy
);

    localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 1);
    localparam int unsigned TRANS_W = $clog2(MAX_TRANSACTION + 1);
    localparam int unsigned SUM_W   = CREDIT_W + 1;

    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);
    localparam logic [TRANS_W-1:0] TRANS_FULL = TRANS_W'(MAX_TRANSACTION);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_ITEMS - 1);

    state_e               state, state_d;
    logic [CREDIT_W-1:0]  credit_d;
    logic [STOCK_W-1:0]   stock   [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [TRANS_W-1:0]   trans_left, trans_d;

    logic                 disp_valid_q, disp_valid_d;
    logic [IDX_W-1:0]     disp_idx_q, disp_idx_d;
    logic                 chg_valid_q, chg_valid_d;
    coin_e                chg_code_q, chg_code_d;
    logic [VAL_W-1:0]     chg_val_q, chg_val_d;
    logic                 coin_reject_d, low_credit_d, busy_d;

    logic [SUM_W-1:0]     coin_sum;
    logic [CREDIT_W-1:0]  price;
    chg_pick_t            pick_c;

    // The next change coin is chosen from the credit that will be held next cycle.
    change_picker #(.CREDIT_W(CREDIT_W)) u_change_picker (
        .credit (credit_d),
        .pick_c (pick_c)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= ST_IDLE;
            credit       <= '0;
            trans_left   <= TRANS_FULL;
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= STOCK_FULL;
            end
            disp_valid_q <= 1'b0;
            disp_idx_q   <= '0;
            chg_valid_q  <= 1'b0;
            chg_code_q   <= COIN_1;
            chg_val_q    <= '0;
            coin_reject  <= 1'b0;
            low_credit   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            trans_left   <= trans_d;
            stock        <= stock_d;
            disp_valid_q <= disp_valid_d;
            disp_idx_q   <= disp_idx_d;
            chg_valid_q  <= chg_valid_d;
            chg_code_q   <= chg_code_d;
            chg_val_q    <= chg_val_d;
            coin_reject  <= coin_reject_d;
            low_credit   <= low_credit_d;
            busy         <= busy_d;
        end
    end

    // Next state, credit, stock and session bookkeeping.
    always_comb begin
        state_d       = state;
        credit_d      = credit;
        stock_d       = stock;
        trans_d       = trans_left;
        disp_idx_d    = disp_idx_q;
        coin_reject_d = 1'b0;
        low_credit_d  = 1'b0;
        coin_sum      = {1'b0, credit} + SUM_W'(coin_value(coin_code));
        price         = free_mode ? '0 : CREDIT_W'(item_price(sel_idx));

        case (state)
            ST_IDLE: begin
                if (refund_req) begin
                    if (credit != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    if (sel_idx <= LAST_IDX) begin
                        if (stock[sel_idx] != '0 && trans_left != '0) begin
                            if (credit < price) begin
                                low_credit_d = 1'b1;
                            end else begin
                                credit_d         = credit - price;
                                stock_d[sel_idx] = stock[sel_idx] - STOCK_W'(1);
                                trans_d          = trans_left - TRANS_W'(1);
                                disp_idx_d       = sel_idx;
                                state_d          = ST_VEND;
                            end
                        end
                    end
                end else if (restock) begin
                    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                        stock_d[i] = STOCK_FULL;
                    end
                end else if (coin_valid) begin
                    if (!coin_code_ok(coin_code) || coin_sum[CREDIT_W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end
                end
                // A coin sharing its cycle with a higher-priority request is lost.
                if (coin_valid && (refund_req || sel_valid || restock)) begin
                    coin_reject_d = 1'b1;
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (disp_valid_q && bus.disp_ready) begin
                    if (trans_left != '0) begin
                        state_d = ST_IDLE;
                    end else if (credit != '0) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                        trans_d = TRANS_FULL;
                    end
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (chg_valid_q && bus.chg_ready) begin
                    credit_d = credit - CREDIT_W'(chg_val_q);
                    if (credit_d == '0) begin
                        state_d = ST_IDLE;
                        trans_d = TRANS_FULL;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered handshake outputs follow the next state.
    always_comb begin
        disp_valid_d = (state_d == ST_VEND);
        chg_valid_d  = (state_d == ST_CHANGE);
        chg_code_d   = chg_valid_d ? pick_c.code  : COIN_1;
        chg_val_d    = chg_valid_d ? pick_c.value : '0;
        busy_d       = (state_d != ST_IDLE);
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            sold_out[i] = (stock[i] == '0);
        end
    end

    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_idx   = disp_idx_q;
    assign bus.chg_valid  = chg_valid_q;
    assign bus.chg_code   = chg_code_q;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Bench for vend_txn_sequencer: directed scenarios plus random traffic against a
// transaction-level model of credit, stock and session rules.
module tb_vend_txn_sequencer;

    logic       CLK;
    logic       RSTn;
    logic       coin_valid;
    logic [2:0] coin_code;
    logic       sel_valid;
    logic [3:0] sel_idx;
    logic       refund_req;
    logic       free_mode;
    logic       restock;
    logic       disp_ready;
    logic       chg_ready;
    logic [7:0] credit;
    logic [9:0] sold_out;
    logic       coin_reject;
    logic       low_credit;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    vend_txn_sequencer_if vif ();
    assign vif.disp_ready = disp_ready;
    assign vif.chg_ready  = chg_ready;

    vend_txn_sequencer dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .refund_req  (refund_req),
        .free_mode   (free_mode),
        .restock     (restock),
        .bus         (vif),
        .credit      (credit),
        .sold_out    (sold_out),
        .coin_reject (coin_reject),
        .low_credit  (low_credit),
        .busy        (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: mode 0 idle, 1 dispensing an item, 2 paying out change.
    localparam int PRICE [10] = '{5, 20, 7, 10, 20, 25, 30, 10, 25, 50};
    localparam int DENOM [5]  = '{20, 10, 5, 2, 1};
    int m_mode;
    int m_credit;
    int m_trans;
    int m_idx;
    int m_stock [10];
    bit exp_rej;
    bit exp_low;

    function automatic int coin_val(input int code);
        case (code)
            0: return 1;
            1: return 2;
            2: return 5;
            3: return 10;
            4: return 20;
            default: return 0;
        endcase
    endfunction

    // Coin code of the largest denomination that fits in c.
    function automatic int greedy_code(input int c);
        for (int i = 0; i < 5; i++) begin
            if (c >= DENOM[i]) return 4 - i;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_credit = 0; m_trans = 3; m_idx = 0;
        exp_rej = 0; exp_low = 0;
        for (int i = 0; i < 10; i++) m_stock[i] = 3;
    endfunction

    function automatic void model_step();
        int v;
        int p;
        exp_rej = 0;
        exp_low = 0;
        if (m_mode == 0) begin
            if (refund_req) begin
                if (m_credit > 0) m_mode = 2;
            end else if (sel_valid) begin
                if (int'(sel_idx) < 10 && m_stock[sel_idx] > 0 && m_trans > 0) begin
                    p = free_mode ? 0 : PRICE[sel_idx];
                    if (m_credit < p) exp_low = 1;
                    else begin
                        m_credit -= p;
                        m_stock[sel_idx] -= 1;
                        m_trans -= 1;
                        m_idx = int'(sel_idx);
                        m_mode = 1;
                    end
                end
            end else if (restock) begin
                for (int i = 0; i < 10; i++) m_stock[i] = 3;
            end else if (coin_valid) begin
                v = coin_val(int'(coin_code));
                if (v == 0 || m_credit + v > 255) exp_rej = 1;
                else m_credit += v;
            end
            if (coin_valid && (refund_req || sel_valid || restock)) exp_rej = 1;
        end else if (m_mode == 1) begin
            exp_rej = coin_valid;
            if (disp_ready) begin
                if (m_trans > 0) m_mode = 0;
                else if (m_credit > 0) m_mode = 2;
                else begin m_mode = 0; m_trans = 3; end
            end
        end else begin
            exp_rej = coin_valid;
            if (chg_ready) begin
                m_credit -= DENOM[4 - greedy_code(m_credit)];
                if (m_credit == 0) begin m_mode = 0; m_trans = 3; end
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            logic [9:0] es;
            for (int i = 0; i < 10; i++) es[i] = (m_stock[i] == 0);
            check("credit", int'(credit), m_credit);
            check("busy", int'(busy), int'(m_mode != 0));
            check("disp_valid", int'(vif.disp_valid), int'(m_mode == 1));
            if (m_mode == 1) check("disp_idx", int'(vif.disp_idx), m_idx);
            check("chg_valid", int'(vif.chg_valid), int'(m_mode == 2));
            if (m_mode == 2) check("chg_code", int'(vif.chg_code), greedy_code(m_credit));
            check("coin_reject", int'(coin_reject), int'(exp_rej));
            check("low_credit", int'(low_credit), int'(exp_low));
            check("sold_out", int'(sold_out), int'(es));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        if (RSTn) model_step();
        else model_reset();
        #1;
        coin_valid = 0; sel_valid = 0; refund_req = 0; restock = 0;
    endtask

    task automatic coin(input int code);
        coin_valid = 1; coin_code = 3'(code); cyc();
    endtask

    task automatic sel(input int idx);
        sel_valid = 1; sel_idx = 4'(idx); cyc();
    endtask

    task automatic refund();
        refund_req = 1; cyc();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin cyc(); n++; end
        check(name, int'(busy), 0);
    endtask

    initial begin
        RSTn = 0; coin_valid = 0; coin_code = 0; sel_valid = 0; sel_idx = 0;
        refund_req = 0; free_mode = 0; restock = 0; disp_ready = 0; chg_ready = 0;
        model_reset();
        repeat (3) cyc();
        RSTn = 1;
        cmp_en = 1;
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sold_out", int'(sold_out), 0);
        check("rst_disp_valid", int'(vif.disp_valid), 0);
        check("rst_chg_valid", int'(vif.chg_valid), 0);

        // $10 + $5, buy tea, stall the dispenser
        coin(3); coin(2);
        check("t1_credit15", int'(credit), 15);
        check("t1_model_pin", m_credit, 15);
        sel(0);
        check("t1_disp_valid", int'(vif.disp_valid), 1);
        check("t1_disp_idx", int'(vif.disp_idx), 0);
        check("t1_credit10", int'(credit), 10);
        repeat (3) cyc();
        check("t1_disp_hold", int'(vif.disp_valid), 1);
        disp_ready = 1; cyc(); disp_ready = 0;
        check("t1_disp_done", int'(vif.disp_valid), 0);
        check("t1_idle", int'(busy), 0);

        // clear the $10, then refund exactly 18
        chg_ready = 1; refund(); wait_idle("t2_clear_idle");
        coin(3); coin(2); coin(1); coin(0);
        check("t2_credit18", int'(credit), 18);
        refund();
        check("t2_code10", int'(vif.chg_code), 3);
        check("t2_chg_valid", int'(vif.chg_valid), 1);
        cyc(); check("t2_code5", int'(vif.chg_code), 2); check("t2_credit8", int'(credit), 8);
        cyc(); check("t2_code2", int'(vif.chg_code), 1); check("t2_credit3", int'(credit), 3);
        cyc(); check("t2_code1", int'(vif.chg_code), 0); check("t2_credit1", int'(credit), 1);
        cyc();
        check("t2_chg_off", int'(vif.chg_valid), 0);
        check("t2_credit0", int'(credit), 0);
        check("t2_busy_off", int'(busy), 0);
        chg_ready = 0;

        // too little for coffee
        coin(2); sel(2);
        check("t3_low_credit", int'(low_credit), 1);
        check("t3_no_disp", int'(vif.disp_valid), 0);
        check("t3_credit5", int'(credit), 5);
        cyc();
        check("t3_low_pulse", int'(low_credit), 0);

        // saturation at 250 + $10, and an invalid code
        for (int i = 0; i < 12; i++) coin(4);
        coin(2);
        check("t4_credit250", int'(credit), 250);
        coin(3);
        check("t4_reject", int'(coin_reject), 1);
        check("t4_credit_kept", int'(credit), 250);
        coin(6);
        check("t4_bad_code", int'(coin_reject), 1);
        chg_ready = 1; refund(); wait_idle("t4_drain_idle"); chg_ready = 0;

        // free vends of idx9 until sold out
        free_mode = 1; disp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            sel(9);
            check("t5_disp", int'(vif.disp_valid), 1);
            check("t5_idx", int'(vif.disp_idx), 9);
            cyc();
        end
        check("t5_sold9", int'(sold_out[9]), 1);
        check("t5_model_stock", m_stock[9], 0);
        sel(9);
        check("t5_ignored", int'(vif.disp_valid), 0);
        check("t5_idle", int'(busy), 0);
        free_mode = 0;

        // three cookie vends exhaust the session and trigger auto change
        for (int i = 0; i < 5; i++) coin(4);
        check("t6_credit100", int'(credit), 100);
        for (int k = 0; k < 3; k++) begin sel(1); cyc(); end
        check("t6_auto_change", int'(vif.chg_valid), 1);
        check("t6_code20", int'(vif.chg_code), 4);
        check("t6_credit40", int'(credit), 40);
        chg_ready = 1;
        cyc(); check("t6_credit20", int'(credit), 20); check("t6_code20b", int'(vif.chg_code), 4);
        cyc(); check("t6_done", int'(vif.chg_valid), 0); check("t6_credit0", int'(credit), 0);
        check("t6_sold1", int'(sold_out[1]), 1);
        check("t6_model_trans", m_trans, 3);
        disp_ready = 0; chg_ready = 0;

        // reset in the middle of a payout
        coin(4); coin(4); refund(); cyc();
        check("t7_in_change", int'(vif.chg_valid), 1);
        RSTn = 0; model_reset(); #1;
        check("t7_credit", int'(credit), 0);
        check("t7_chg_valid", int'(vif.chg_valid), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_sold_out", int'(sold_out), 0);
        repeat (2) cyc();
        RSTn = 1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            coin_valid = ($urandom_range(0, 3) == 0);
            coin_code  = 3'($urandom_range(0, 7));
            sel_valid  = ($urandom_range(0, 6) == 0);
            sel_idx    = 4'($urandom_range(0, 11));
            refund_req = ($urandom_range(0, 24) == 0);
            restock    = ($urandom_range(0, 39) == 0);
            free_mode  = ($urandom_range(0, 9) == 0);
            disp_ready = 1'($urandom_range(0, 1));
            chg_ready  = ($urandom_range(0, 4) != 0);
            cyc();
        end
        free_mode = 0; disp_ready = 1; chg_ready = 1;
        wait_idle("final_idle");
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vend_txn_sequencer.md
Name: vend_txn_sequencer

Overview:
- Transaction controller for the vending machine credit/stock datapath.
- Accepts coin events, item selections and refund requests, then checks price, stock and the per-session transaction limit.
- Sequences item dispensing and greedy change return through ready/valid handshakes.
- Sits between the front-panel decode logic and the item and coin dispenser mechanisms.
- Owns the credit register, per-item stock counters and the session transaction counter.

Parameters:
- NUM_ITEMS, 10, number of selectable items; index 0..9 = tea, cookies, coffee, candy1-3, choc1-4.
- CREDIT_W, 8, credit register width; credit saturates at 2^CREDIT_W-1.
- STOCK_INIT, 3, stock count loaded at reset and on restock.
- MAX_TRANSACTION, 3, vends allowed per session.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- coin_valid  in  1  single-cycle coin event.
- coin_code  in  3  coin code: 0=$1, 1=$2, 2=$5, 3=$10, 4=$20; 5-7 invalid.
- sel_valid  in  1  single-cycle item select.
- sel_idx  in  4  item index.
- refund_req  in  1  single-cycle refund request.
- free_mode  in  1  service mode: price treated as 0.
- restock  in  1  single-cycle reload of all stock counters.
- disp_valid  out  1  item dispense request.
- disp_idx  out  4  item being dispensed.
- disp_ready  in  1  item dispenser accept.
- chg_valid  out  1  change coin request.
- chg_code  out  3  change coin code, same encoding as coin_code.
- chg_ready  in  1  coin dispenser accept.
- credit  out  CREDIT_W  current credit in dollars.
- sold_out  out  NUM_ITEMS  bit i = 1 when stock[i]==0.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- low_credit  out  1  one-cycle pulse: selection refused for price.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, credit=0 (in-flight credit is discarded), stock[i]=STOCK_INIT, trans_left=MAX_TRANSACTION.
  - All outputs 0 except sold_out=0.
- FSM states: IDLE, VEND, CHANGE.
- IDLE, priority refund_req > sel_valid > restock > coin_valid; a coin arriving in a cycle also carrying refund/sel/restock is rejected (coin_reject=1).
  - refund_req:
    - credit>0 -> CHANGE.
    - credit==0 -> no action.
  - sel_valid:
    - sel_idx>=NUM_ITEMS -> ignored.
    - stock==0 or trans_left==0 -> ignored; no pulse.
    - credit<price and !free_mode -> low_credit pulse.
    - otherwise, registered next cycle:
      - credit -= price (0 if free_mode).
      - stock[idx]--, trans_left--.
      - disp_idx=idx, disp_valid=1.
      - -> VEND.
  - restock: all stock[i]=STOCK_INIT.
  - coin_valid:
    - Invalid code -> coin_reject.
    - credit+value > 2^CREDIT_W-1 -> coin_reject; credit unchanged.
    - Else credit += value.
- VEND:
  - disp_valid/disp_idx held stable until the cycle with disp_ready=1 (handshake cycle).
  - Next state after the handshake:
    - IDLE if trans_left>0.
    - CHANGE if trans_left==0 and credit>0.
    - IDLE with trans_left reloaded if trans_left==0 and credit==0.
  - All coins rejected; sel/refund/restock ignored.
- CHANGE:
  - chg_valid=1; chg_code = largest denomination <= credit (20, 10, 5, 2, 1), recomputed after each accept.
  - On chg_valid&chg_ready: credit -= value.
  - When credit reaches 0: chg_valid deasserts the following cycle, trans_left reloads to MAX_TRANSACTION, -> IDLE.
  - Coins rejected; other inputs ignored.
- Latency:
  - Selection to disp_valid: 1 cycle.
  - Refund to first chg_valid: 1 cycle.
  - One coin per accepted handshake; back-to-back accepts are legal.
- Width rules: all credit arithmetic unsigned CREDIT_W; subtraction never underflows (guarded by the checks above).
- sold_out is combinational from the stock counters.
- free_mode is sampled only at the select cycle.

Decomposition:
- Package vend_pkg holds:
  - Price constants: tea 5, cookies 20, coffee 7, candy 10/20/25, choc 30/10/25/50.
  - Coin code enum and code->value function.
  - FSM state enum.
- One sub-module, change_picker: combinational, credit -> largest chg_code and value.

Test Plan:
- $10 + $5 coins, select idx0 (tea) -> disp_valid idx0 next cycle, credit 15->10; hold disp_ready=0 for 3 cycles -> disp_valid stays high; disp_ready=1 -> IDLE.
- Credit 18, refund_req with chg_ready always 1 -> chg_code 3,2,1,0 ($10,$5,$2,$1) on consecutive cycles; credit 0; IDLE; busy falls.
- Credit 5, select idx2 (coffee, 7) -> low_credit pulse, no disp_valid, credit stays 5.
- Credit 250, insert $10 -> coin_reject, credit stays 250.
- free_mode=1, select idx9 four times -> stock 3->0, sold_out[9]=1; fourth select ignored; trans_left hits 0 after the third vend.
- Credit 100, three $20 vends (idx1) -> after the third handshake, auto CHANGE returns $20,$20; trans_left reloaded to 3.
- Assert RSTn low mid-CHANGE -> outputs 0, credit 0, stock reloaded to 3, FSM=IDLE.
